// File: rtl/fsm_climate_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : fsm_climate_ctrl
// Purpose  : Climate controller FSM with debounced power button, hysteresis,
//            minimum heat/cool dwell and four operating modes.
// Revision : 1.0
// =============================================================================
module fsm_climate_ctrl #(
   parameter int TEMP_W     = 4,
   parameter int HYST       = 1,
   parameter int DEB_CYCLES = 4,
   parameter int MIN_ON     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bt,
   input  logic [TEMP_W-1:0] temp,
   input  logic [TEMP_W-1:0] setpoint,
   input  logic [1:0]        mode,
   output logic [2:0]        state,
   output logic              heat,
   output logic              cool,
   output logic              fan,
   output logic              press
);

   typedef enum logic [2:0] {
      S_OFF  = 3'd0,
      S_IDLE = 3'd1,
      S_HEAT = 3'd2,
      S_COOL = 3'd3,
      S_FAN  = 3'd4
   } state_e;

   localparam int                DEB_W   = $clog2(DEB_CYCLES + 1);
   localparam int                DW_W    = $clog2(MIN_ON) + 1;
   localparam logic [DEB_W-1:0]  DEB_MAX = DEB_W'(DEB_CYCLES);
   localparam logic [DEB_W-1:0]  DEB_ARM = DEB_W'(DEB_CYCLES - 1);
   localparam logic [DW_W-1:0]   DW_LOAD = DW_W'(MIN_ON - 1);
   localparam logic [TEMP_W:0]   HYST_X  = (TEMP_W + 1)'(HYST);

   logic             bt_s1_q, bt_s1_d;
   logic             bt_s2_q, bt_s2_d;
   logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
   logic             press_q, press_d;
   logic [2:0]       state_q, state_d;
   logic [DW_W-1:0]  dwell_q, dwell_d;

   logic [TEMP_W:0]  temp_x, sp_x;
   logic             cold, warm, at_sp_h, at_sp_c;
   logic             heat_ok, cool_ok, fan_ok, expired;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bt_s1_q   <= 1'b0;
         bt_s2_q   <= 1'b0;
         deb_cnt_q <= '0;
         press_q   <= 1'b0;
         state_q   <= S_OFF;
         dwell_q   <= '0;
      end else begin
         bt_s1_q   <= bt_s1_d;
         bt_s2_q   <= bt_s2_d;
         deb_cnt_q <= deb_cnt_d;
         press_q   <= press_d;
         state_q   <= state_d;
         dwell_q   <= dwell_d;
      end
   end

   // Counter saturates at DEB_MAX so a held button cannot retrigger.
   always_comb begin
      bt_s1_d   = bt;
      bt_s2_d   = bt_s1_q;
      deb_cnt_d = '0;
      press_d   = 1'b0;
      if (bt_s2_q) begin
         deb_cnt_d = (deb_cnt_q == DEB_MAX) ? DEB_MAX : deb_cnt_q + DEB_W'(1);
         press_d   = (deb_cnt_q == DEB_ARM);
      end
   end

   always_comb begin
      temp_x  = {1'b0, temp};
      sp_x    = {1'b0, setpoint};
      cold    = (temp_x + HYST_X) < sp_x;
      warm    = temp_x > (sp_x + HYST_X);
      at_sp_h = temp_x >= sp_x;
      at_sp_c = temp_x <= sp_x;
      heat_ok = ~mode[1];
      cool_ok = ~mode[0];
      fan_ok  = &mode;
      expired = (dwell_q == '0);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_OFF: begin
            if (press_q) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (press_q)                state_d = S_OFF;
            else if (fan_ok)            state_d = S_FAN;
            else if (cold && heat_ok)   state_d = S_HEAT;
            else if (warm && cool_ok)   state_d = S_COOL;
         end
         S_HEAT: begin
            if (press_q)                state_d = S_OFF;
            else if (!heat_ok)          state_d = S_IDLE;
            else if (at_sp_h && expired) state_d = S_IDLE;
         end
         S_COOL: begin
            if (press_q)                state_d = S_OFF;
            else if (!cool_ok)          state_d = S_IDLE;
            else if (at_sp_c && expired) state_d = S_IDLE;
         end
         S_FAN: begin
            if (press_q)                state_d = S_OFF;
            else if (!fan_ok)           state_d = S_IDLE;
         end
         default: state_d = S_OFF;
      endcase
   end

   always_comb begin
      dwell_d = dwell_q;
      if ((state_d == S_HEAT || state_d == S_COOL) && (state_d != state_q))
         dwell_d = DW_LOAD;
      else if (!expired)
         dwell_d = dwell_q - DW_W'(1);
   end

   always_comb begin
      heat = 1'b0;
      cool = 1'b0;
      fan  = 1'b0;
      case (state_q)
         S_HEAT: begin
            heat = 1'b1;
            fan  = 1'b1;
         end
         S_COOL: begin
            cool = 1'b1;
            fan  = 1'b1;
         end
         S_FAN:   fan = 1'b1;
         default: fan = 1'b0;
      endcase
   end

   assign state = state_q;
   assign press = press_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_climate_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_fsm_climate_ctrl
// Purpose  : Directed self-checking bench for fsm_climate_ctrl (HYST=1 and HYST=2).
// Revision : 1.0
// =============================================================================
module tb_fsm_climate_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       bt;
   logic [3:0] temp;
   logic [3:0] setpoint;
   logic [1:0] mode;
   logic [2:0] state, state2;
   logic       heat, cool, fan, press;
   logic       heat2, cool2, fan2, press2;

   int n_chk  = 0;
   int n_fail = 0;
   int lat;
   int npress;
   int pidx;

   always #5 clk = ~clk;

   fsm_climate_ctrl #(.TEMP_W(4), .HYST(1), .DEB_CYCLES(4), .MIN_ON(8)) dut (
      .clk(clk), .rst_n(rst_n), .bt(bt), .temp(temp), .setpoint(setpoint), .mode(mode),
      .state(state), .heat(heat), .cool(cool), .fan(fan), .press(press)
   );

   fsm_climate_ctrl #(.TEMP_W(4), .HYST(2), .DEB_CYCLES(4), .MIN_ON(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .bt(bt), .temp(temp), .setpoint(setpoint), .mode(mode),
      .state(state2), .heat(heat2), .cool(cool2), .fan(fan2), .press(press2)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      chk("excl1", int'(heat & cool), 0);
      chk("excl2", int'(heat2 & cool2), 0);
   endtask

   // Returns the number of ticks from bt rising to the press pulse (0 if none).
   task automatic press_btn(output int l);
      l  = 0;
      bt = 1'b1;
      for (int k = 1; k <= 12 && l == 0; k++) begin
         tick();
         if (press) l = k;
      end
      bt = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; bt = 1'b1; mode = 2'b00; temp = 4'd8; setpoint = 4'd8;

      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_state", int'(state), 0);
         chk("rst_outs", int'({heat, cool, fan, press}), 0);
      end

      rst_n = 1'b1; npress = 0; pidx = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (press) begin npress++; pidx = k; end
         if (k == 6) chk("pre_on_state", int'(state), 0);
         if (k == 7) chk("on_state", int'(state), 1);
      end
      chk("press_count", npress, 1);
      chk("press_lat", pidx, 6);
      bt = 1'b0;

      repeat (4) tick();
      bt = 1'b1;
      repeat (3) tick();
      bt = 1'b0;
      npress = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (press) npress++;
      end
      chk("glitch_press", npress, 0);
      chk("glitch_state", int'(state), 1);

      temp = 4'd7;
      repeat (3) tick();
      chk("t7_idle", int'(state), 1);
      temp = 4'd6;
      tick();
      chk("t6_heat", int'(state), 2);
      chk("t6_outs", int'({heat, cool, fan}), 3'b101);
      chk("t6_hyst2_idle", int'(state2), 1);
      temp = 4'd9;
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("heat_dwell", int'(state), 2);
      end
      tick();
      chk("heat_exit", int'(state), 1);

      temp = 4'd12;
      tick();
      chk("cool_enter", int'(state), 3);
      chk("cool_outs", int'({heat, cool, fan}), 3'b011);
      chk("cool_enter2", int'(state2), 3);
      repeat (8) tick();
      chk("cool_hold", int'(state), 3);
      temp = 4'd2;
      tick();
      chk("cool_exit", int'(state), 1);
      tick();
      chk("idle_to_heat", int'(state), 2);
      chk("idle_to_heat2", int'(state2), 2);

      repeat (2) tick();
      mode = 2'b10;
      tick();
      chk("mode_override", int'(state), 1);
      chk("mode_override2", int'(state2), 1);
      tick();
      chk("mode10_cold_idle", int'(state), 1);
      temp = 4'd9;
      tick();
      chk("mode10_t9_idle", int'(state), 1);
      temp = 4'd10;
      tick();
      chk("mode10_t10_cool", int'(state), 3);
      chk("mode10_t10_hyst2", int'(state2), 1);

      mode = 2'b11;
      tick();
      chk("fan_cool_exit", int'(state), 1);
      chk("fan_enter2", int'(state2), 4);
      tick();
      chk("fan_enter", int'(state), 4);
      chk("fan_outs", int'({heat, cool, fan}), 3'b001);
      press_btn(lat);
      chk("off_lat", lat, 6);
      chk("off_state", int'(state), 0);
      chk("off_fan", int'(fan), 0);
      chk("off_state2", int'(state2), 0);
      tick();
      press_btn(lat);
      chk("on_again", int'(state), 1);
      tick();
      chk("fan_again", int'(state), 4);

      mode = 2'b00; setpoint = 4'd0; temp = 4'd0;
      tick();
      chk("sp0_idle", int'(state2), 1);
      repeat (3) tick();
      chk("sp0_no_heat", int'(state2), 1);
      chk("sp0_heat_out", int'(heat2), 0);
      setpoint = 4'd15; temp = 4'd15;
      repeat (4) tick();
      chk("sp15_no_cool", int'(state2), 1);
      chk("sp15_cool_out", int'(cool2), 0);
      chk("sp15_no_cool1", int'(state), 1);

      force dut.state_q = 3'd6;
      #1;
      chk("forced_code", int'(state), 6);
      chk("forced_outs", int'({heat, cool, fan}), 0);
      @(posedge clk);
      #1;
      release dut.state_q;
      tick();
      tick();
      chk("illegal_to_off", int'(state), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
